// File: rtl/vend_pkg.sv
// vend_pkg: shared constants, types and helpers for the vending controller.
// Optional feature macro used elsewhere in this slice: VEND_SALES_CNT_EN.
package vend_pkg;

  // Width of credit and price arithmetic.
  localparam int CREDIT_W = 9;

  // change_rem carries one extra bit so bounced coins on top of a full
  // credit (up to MAX_CREDIT plus a burst of coins) never wrap.
  localparam int REM_W = CREDIT_W + 1;

  localparam int COIN_5  = 5;
  localparam int COIN_10 = 10;
  localparam int COIN_25 = 25;

  typedef logic [CREDIT_W-1:0] credit_t;
  typedef logic [REM_W-1:0]    rem_t;

  typedef enum logic {
    IDLE,
    CHANGE
  } vend_state_t;

  // Value of all coins detected in one cycle; simultaneous detects add up.
  function automatic rem_t coin_sum(input logic d5, input logic d10, input logic d25);
    rem_t s;
    s = '0;
    if (d5)  s = s + rem_t'(COIN_5);
    if (d10) s = s + rem_t'(COIN_10);
    if (d25) s = s + rem_t'(COIN_25);
    return s;
  endfunction

  // Add coins to the pending change without ever wrapping the register.
  function automatic rem_t sat_add_rem(input rem_t a, input rem_t b);
    logic [REM_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[REM_W] ? '1 : s[REM_W-1:0];
  endfunction

endpackage

// File: rtl/vend_if.sv
// vend_if: coin/buy/return bundle between the front end and the controller.
// master = coin acceptor / keypad / tube sensors side, slave = vend_ctrl.
interface vend_if;
  import vend_pkg::*;

  logic    detect_5;
  logic    detect_10;
  logic    detect_25;
  logic    buy;
  logic    return_coins;
  credit_t amount;
  logic    empty_5;
  logic    empty_10;
  logic    empty_25;

  logic    ok;
  logic    return_5;
  logic    return_10;
  logic    return_25;
  credit_t total;
  logic    busy;

  modport master (
    output detect_5, detect_10, detect_25, buy, return_coins, amount,
           empty_5, empty_10, empty_25,
    input  ok, return_5, return_10, return_25, total, busy
  );

  modport slave (
    input  detect_5, detect_10, detect_25, buy, return_coins, amount,
           empty_5, empty_10, empty_25,
    output ok, return_5, return_10, return_25, total, busy
  );

endinterface

// File: rtl/vend_change_sel.sv
// vend_change_sel: greedy single-coin picker for dispensing change.
// Picks the largest coin that fits in change_rem and whose tube is not empty.
module vend_change_sel
  import vend_pkg::*;
(
  input  rem_t       change_rem,
  input  logic       empty_5,
  input  logic       empty_10,
  input  logic       empty_25,
  output logic [2:0] coin_sel,
  output rem_t       coin_val
);

  // Largest coin first; coin_sel is one-hot {25,10,5}, all zero when nothing fits.
  always_comb begin
    coin_sel = 3'b000;
    coin_val = '0;
    if ((change_rem >= rem_t'(COIN_25)) && !empty_25) begin
      coin_sel = 3'b100;
      coin_val = rem_t'(COIN_25);
    end else if ((change_rem >= rem_t'(COIN_10)) && !empty_10) begin
      coin_sel = 3'b010;
      coin_val = rem_t'(COIN_10);
    end else if ((change_rem >= rem_t'(COIN_5)) && !empty_5) begin
      coin_sel = 3'b001;
      coin_val = rem_t'(COIN_5);
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: vending-machine controller, responder end of coin/buy/return.
// Credits coins, accepts or rejects purchases, pays change one coin a cycle.
// Define VEND_SALES_CNT_EN to add a saturating sales_cnt output.
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int MAX_CREDIT = 500
) (
  input  logic        clk,
  input  logic        rst,
  vend_if.slave       bus
`ifdef VEND_SALES_CNT_EN
  ,
  output logic [15:0] sales_cnt
`endif
);

  localparam rem_t MAX_CREDIT_R = rem_t'(MAX_CREDIT);

  vend_state_t    state_q, state_d;
  credit_t        credit_q, credit_d;
  rem_t           change_rem_q, change_rem_d;
  logic           ok_q, ok_d;
  logic [2:0]     ret_q, ret_d;
  logic           busy_q, busy_d;

  rem_t           coins;
  rem_t           intake;
  logic [REM_W:0] refill;
  logic [2:0]     coin_sel;
  rem_t           coin_val;
  logic           accept_buy;

  assign coins = coin_sum(bus.detect_5, bus.detect_10, bus.detect_25);

  vend_change_sel u_change_sel (
    .change_rem (change_rem_q),
    .empty_5    (bus.empty_5),
    .empty_10   (bus.empty_10),
    .empty_25   (bus.empty_25),
    .coin_sel   (coin_sel),
    .coin_val   (coin_val)
  );

  // Credit and pending-change bookkeeping for coin intake, buy, return and payout.
  always_comb begin
    credit_d     = credit_q;
    change_rem_d = change_rem_q;
    accept_buy   = 1'b0;
    intake       = rem_t'(credit_q) + coins;
    refill       = {1'b0, rem_t'(credit_q)} + {1'b0, change_rem_q};
    case (state_q)
      IDLE: begin
        if (bus.buy && (credit_q >= bus.amount)) begin
          accept_buy   = 1'b1;
          change_rem_d = rem_t'(credit_q - bus.amount) + coins;
          credit_d     = '0;
        end else if (bus.return_coins) begin
          change_rem_d = intake;
          credit_d     = '0;
        end else if (intake <= MAX_CREDIT_R) begin
          credit_d = credit_t'(intake);
        end else begin
          change_rem_d = coins;
        end
      end
      CHANGE: begin
        if (coin_sel != 3'b000) begin
          change_rem_d = sat_add_rem(change_rem_q - coin_val, coins);
        end else begin
          credit_d     = (refill > {1'b0, MAX_CREDIT_R}) ? credit_t'(MAX_CREDIT)
                                                         : credit_t'(refill);
          change_rem_d = coins;
        end
      end
      default: begin
        credit_d     = credit_q;
        change_rem_d = change_rem_q;
      end
    endcase
  end

  // Stay in CHANGE while any change is still owed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (change_rem_d != '0) state_d = CHANGE;
      CHANGE:  if (change_rem_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered pulses and busy flag.
  always_comb begin
    ok_d   = accept_buy;
    ret_d  = (state_q == CHANGE) ? coin_sel : 3'b000;
    busy_d = (state_d == CHANGE);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers; reset also abandons any change in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q     <= '0;
      change_rem_q <= '0;
      ok_q         <= 1'b0;
      ret_q        <= 3'b000;
      busy_q       <= 1'b0;
    end else begin
      credit_q     <= credit_d;
      change_rem_q <= change_rem_d;
      ok_q         <= ok_d;
      ret_q        <= ret_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.ok        = ok_q;
  assign bus.return_5  = ret_q[0];
  assign bus.return_10 = ret_q[1];
  assign bus.return_25 = ret_q[2];
  assign bus.total     = credit_q;
  assign bus.busy      = busy_q;

`ifdef VEND_SALES_CNT_EN
  logic [15:0] sales_cnt_q, sales_cnt_d;

  // Count accepted purchases, holding at the top value.
  always_comb begin
    sales_cnt_d = sales_cnt_q;
    if (ok_d && (sales_cnt_q != 16'hFFFF)) begin
      sales_cnt_d = sales_cnt_q + 16'd1;
    end
  end

  // Sales counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sales_cnt_q <= '0;
    end else begin
      sales_cnt_q <= sales_cnt_d;
    end
  end

  assign sales_cnt = sales_cnt_q;
`endif

endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: self-checking bench for vend_ctrl.
// Directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a behavioural credit/change model.
// Honours VEND_SALES_CNT_EN when defined.
module tb_vend_ctrl;
  import vend_pkg::*;

  localparam int MAX_CREDIT = 500;

  logic clk = 1'b0;
  logic rst;
  vend_if bus();
`ifdef VEND_SALES_CNT_EN
  logic [15:0] sales_cnt;
`endif

  int tests    = 0;
  int failures = 0;
  bit check_en = 1'b0;

  // Behavioural model state: credit, owed change, paying-out flag.
  int m_credit;
  int m_rem;
  int m_sales;
  bit m_chg;
  bit exp_ok, exp_r5, exp_r10, exp_r25;

  vend_ctrl #(.MAX_CREDIT(MAX_CREDIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef VEND_SALES_CNT_EN
    ,
    .sales_cnt (sales_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model of the vending rules, advanced once per rising edge.
  always @(posedge clk) begin : model
    int coins;
    int pick;
    exp_ok  = 1'b0;
    exp_r5  = 1'b0;
    exp_r10 = 1'b0;
    exp_r25 = 1'b0;
    if (rst) begin
      m_credit = 0;
      m_rem    = 0;
      m_chg    = 1'b0;
      m_sales  = 0;
    end else begin
      coins = (bus.detect_5 ? 5 : 0) + (bus.detect_10 ? 10 : 0) + (bus.detect_25 ? 25 : 0);
      if (!m_chg) begin
        if (bus.buy && (m_credit >= int'(bus.amount))) begin
          exp_ok   = 1'b1;
          m_rem    = m_credit - int'(bus.amount) + coins;
          m_credit = 0;
          if (m_sales < 65535) m_sales++;
        end else if (bus.return_coins) begin
          m_rem    = m_credit + coins;
          m_credit = 0;
        end else if (m_credit + coins <= MAX_CREDIT) begin
          m_credit = m_credit + coins;
        end else begin
          m_rem = coins;
        end
      end else begin
        pick = 0;
        if (m_rem >= 25 && !bus.empty_25) begin
          pick = 25; exp_r25 = 1'b1;
        end else if (m_rem >= 10 && !bus.empty_10) begin
          pick = 10; exp_r10 = 1'b1;
        end else if (m_rem >= 5 && !bus.empty_5) begin
          pick = 5; exp_r5 = 1'b1;
        end
        if (pick > 0) begin
          m_rem = m_rem - pick + coins;
        end else begin
          m_credit = (m_credit + m_rem > MAX_CREDIT) ? MAX_CREDIT : m_credit + m_rem;
          m_rem    = coins;
        end
      end
      m_chg = (m_rem != 0);
    end
  end

  // Compare every output against the model, away from the rising edge.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("ok",        int'(bus.ok),        int'(exp_ok));
      checkOutput("return_5",  int'(bus.return_5),  int'(exp_r5));
      checkOutput("return_10", int'(bus.return_10), int'(exp_r10));
      checkOutput("return_25", int'(bus.return_25), int'(exp_r25));
      checkOutput("total",     int'(bus.total),     m_credit);
      checkOutput("busy",      int'(bus.busy),      int'(m_chg));
`ifdef VEND_SALES_CNT_EN
      checkOutput("sales_cnt", int'(sales_cnt),     m_sales);
`endif
    end
  end

  task automatic applyStimulus(input bit d5, input bit d10, input bit d25,
                               input bit b, input bit r, input int amt);
    bus.detect_5     = d5;
    bus.detect_10    = d10;
    bus.detect_25    = d25;
    bus.buy          = b;
    bus.return_coins = r;
    bus.amount       = credit_t'(amt);
    @(posedge clk);
    #1;
    bus.detect_5     = 1'b0;
    bus.detect_10    = 1'b0;
    bus.detect_25    = 1'b0;
    bus.buy          = 1'b0;
    bus.return_coins = 1'b0;
  endtask

  task automatic insertCoin(input int c);
    applyStimulus(c == 5, c == 10, c == 25, 1'b0, 1'b0, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    bus.empty_5  = 1'b0;
    bus.empty_10 = 1'b0;
    bus.empty_25 = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int n10, n25, amt;
    rst              = 1'b1;
    bus.detect_5     = 1'b0;
    bus.detect_10    = 1'b0;
    bus.detect_25    = 1'b0;
    bus.buy          = 1'b0;
    bus.return_coins = 1'b0;
    bus.amount       = '0;
    bus.empty_5      = 1'b0;
    bus.empty_10     = 1'b0;
    bus.empty_25     = 1'b0;
    @(posedge clk);
    #1;
    check_en = 1'b1;
    rst      = 1'b0;
    checkOutput("reset_total", int'(bus.total), 0);
    checkOutput("reset_busy",  int'(bus.busy),  0);
    checkOutput("reset_ok",    int'(bus.ok),    0);

    // 25+25+10, buy 45: ok, then a 10 and a 5 back
    insertCoin(25); insertCoin(25); insertCoin(10);
    checkOutput("t1_total", int'(bus.total), 60);
    checkOutput("t1_model_total", m_credit, 60);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 45);
    checkOutput("t1_ok", int'(bus.ok), 1);
    checkOutput("t1_total_after_buy", int'(bus.total), 0);
    checkOutput("t1_busy", int'(bus.busy), 1);
    idle(1);
    checkOutput("t1_ret10", int'(bus.return_10), 1);
    idle(1);
    checkOutput("t1_ret5", int'(bus.return_5), 1);
    checkOutput("t1_busy_end", int'(bus.busy), 0);

    // Unaffordable buy ignored, then refund of 20
    doReset();
    insertCoin(10); insertCoin(10);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 35);
    checkOutput("t2_no_ok", int'(bus.ok), 0);
    checkOutput("t2_total", int'(bus.total), 20);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    checkOutput("t2_total_zero", int'(bus.total), 0);
    idle(1);
    checkOutput("t2_ret10_a", int'(bus.return_10), 1);
    idle(1);
    checkOutput("t2_ret10_b", int'(bus.return_10), 1);
    checkOutput("t2_busy_end", int'(bus.busy), 0);

    // Refund 60 with the 25 tube empty: six 10s
    doReset();
    insertCoin(25); insertCoin(25); insertCoin(10);
    bus.empty_25 = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    n10 = 0;
    n25 = 0;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      n10 += int'(bus.return_10);
      n25 += int'(bus.return_25);
    end
    checkOutput("t3_n10", n10, 6);
    checkOutput("t3_n25", n25, 0);
    checkOutput("t3_busy_end", int'(bus.busy), 0);
    bus.empty_25 = 1'b0;

    // buy 0 with 30 credit and the 5 tube empty: 5 stays as credit
    doReset();
    insertCoin(25); insertCoin(5);
    bus.empty_5 = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    checkOutput("t4_ok", int'(bus.ok), 1);
    idle(1);
    checkOutput("t4_ret25", int'(bus.return_25), 1);
    idle(1);
    checkOutput("t4_total", int'(bus.total), 5);
    checkOutput("t4_model_total", m_credit, 5);
    checkOutput("t4_busy", int'(bus.busy), 0);
    bus.empty_5 = 1'b0;

    // Overflowing coin bounced, plus a coin during CHANGE
    doReset();
    repeat (19) insertCoin(25);
    insertCoin(10); insertCoin(5);
    checkOutput("t5_total", int'(bus.total), 490);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    checkOutput("t5_total_hold", int'(bus.total), 490);
    checkOutput("t5_busy", int'(bus.busy), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    checkOutput("t5_ret25", int'(bus.return_25), 1);
    idle(1);
    checkOutput("t5_ret10", int'(bus.return_10), 1);
    checkOutput("t5_busy_end", int'(bus.busy), 0);
    checkOutput("t5_total_end", int'(bus.total), 490);

    // Reset in the middle of paying out 40
    doReset();
    insertCoin(25); insertCoin(10); insertCoin(5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    checkOutput("t6_busy", int'(bus.busy), 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    checkOutput("t6_total", int'(bus.total), 0);
    checkOutput("t6_busy_rst", int'(bus.busy), 0);
    checkOutput("t6_rets", int'({bus.return_25, bus.return_10, bus.return_5}), 0);
    idle(1);
    checkOutput("t6_idle_rets", int'({bus.return_25, bus.return_10, bus.return_5}), 0);
`ifdef VEND_SALES_CNT_EN
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    checkOutput("t6_sales_cnt", int'(sales_cnt), 3);
`endif

    // Randomized traffic, checked by the per-cycle compare
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) bus.empty_5  = ~bus.empty_5;
      if ($urandom_range(0, 29) == 0) bus.empty_10 = ~bus.empty_10;
      if ($urandom_range(0, 29) == 0) bus.empty_25 = ~bus.empty_25;
      rst = ($urandom_range(0, 399) == 0);
      amt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511))
                                        : int'($urandom_range(0, 150));
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 19) == 0, amt);
    end
    rst = 1'b0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
